// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_sequencer
// Brief    : Word-serial wide add/subtract through one shared WORD_W-bit adder,
//            least-significant word first, with ready/valid on both sides.
// Revision : 1.0  initial release
// ============================================================================
module multiword_add_sequencer #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*WORDS-1:0]  a,
    input  logic [WORD_W*WORDS-1:0]  b,
    input  logic                     cin,
    input  logic                     op_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*WORDS-1:0]  sum,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy
);

    localparam int N     = WORD_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic              carry_q, carry_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    // Operands shift right each ADD cycle, so the active word is always the low one.
    logic [WORD_W-1:0] a_word;
    logic [WORD_W-1:0] b_word;
    logic [WORD_W:0]   add_res;

    assign a_word  = a_q[WORD_W-1:0];
    assign b_word  = b_q[WORD_W-1:0];
    assign add_res = {1'b0, a_word} + {1'b0, b_word} + {{WORD_W{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                a_d     = a_q >> WORD_W;
                b_d     = b_q >> WORD_W;
                carry_d = add_res[WORD_W];
                for (int k = 0; k < WORDS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*WORD_W +: WORD_W] = add_res[WORD_W-1:0];
                    end
                end
                if (idx_q == LAST_IDX) begin
                    // On the last word the operand MSBs are the sign bits of the full-width values.
                    cout_d  = add_res[WORD_W];
                    ovf_d   = (a_word[WORD_W-1] == b_word[WORD_W-1]) &&
                              (add_res[WORD_W-1] != a_word[WORD_W-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiword_add_sequencer
// Brief    : Scoreboard bench for three configurations (32x4, 32x1, 8x3).
// Revision : 1.0  initial release
// ============================================================================
module tb_multiword_add_sequencer;

    typedef struct packed {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] a_in, b_in;
    logic         cin_in, sub_in;
    logic [2:0]   in_valid_v, out_ready_v;

    logic         in_ready0, out_valid0, cout0, ovf0, busy0;
    logic [127:0] sum0;
    logic         in_ready1, out_valid1, cout1, ovf1, busy1;
    logic [31:0]  sum1;
    logic         in_ready2, out_valid2, cout2, ovf2, busy2;
    logic [23:0]  sum2;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   sel     = 0;
    exp_t sb_q[$];

    logic         obs_in_ready, obs_out_valid, obs_cout, obs_ovf, obs_busy;
    logic [127:0] obs_sum;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.WORD_W(32), .WORDS(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready0),
        .a(a_in), .b(b_in), .cin(cin_in), .op_sub(sub_in),
        .out_valid(out_valid0), .out_ready(out_ready_v[0]),
        .sum(sum0), .cout(cout0), .ovf(ovf0), .busy(busy0)
    );

    multiword_add_sequencer #(.WORD_W(32), .WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready1),
        .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in), .op_sub(sub_in),
        .out_valid(out_valid1), .out_ready(out_ready_v[1]),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    multiword_add_sequencer #(.WORD_W(8), .WORDS(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready2),
        .a(a_in[23:0]), .b(b_in[23:0]), .cin(cin_in), .op_sub(sub_in),
        .out_valid(out_valid2), .out_ready(out_ready_v[2]),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2)
    );

    always_comb begin
        obs_in_ready  = in_ready0;
        obs_out_valid = out_valid0;
        obs_cout      = cout0;
        obs_ovf       = ovf0;
        obs_busy      = busy0;
        obs_sum       = sum0;
        if (sel == 1) begin
            obs_in_ready  = in_ready1;
            obs_out_valid = out_valid1;
            obs_cout      = cout1;
            obs_ovf       = ovf1;
            obs_busy      = busy1;
            obs_sum       = {96'b0, sum1};
        end else if (sel == 2) begin
            obs_in_ready  = in_ready2;
            obs_out_valid = out_valid2;
            obs_cout      = cout2;
            obs_ovf       = ovf2;
            obs_busy      = busy2;
            obs_sum       = {104'b0, sum2};
        end
    end

    // Reference: full-width (n+1)-bit arithmetic on the masked operands.
    function automatic exp_t model(input int n, input logic [127:0] av, input logic [127:0] bv,
                                   input logic ci, input logic sub);
        logic [128:0] mask, aa, bb, full;
        exp_t         e;
        mask   = (129'd1 << n) - 129'd1;
        aa     = {1'b0, av} & mask;
        bb     = sub ? (~{1'b0, bv} & mask) : ({1'b0, bv} & mask);
        full   = aa + bb + {128'b0, (sub ? 1'b1 : ci)};
        e.sum  = full[127:0] & mask[127:0];
        e.cout = full[n];
        e.ovf  = (aa[n-1] == bb[n-1]) && (full[n-1] != aa[n-1]);
        return e;
    endfunction

    task automatic run_op(input logic [127:0] av, input logic [127:0] bv, input logic ci,
                          input logic sub, output int lat, output exp_t got);
        int w;
        w = 0;
        while (!obs_in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        a_in = av; b_in = bv; cin_in = ci; sub_in = sub;
        in_valid_v[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[sel] = 1'b0;
        lat = 0;
        while (!obs_out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        got.sum = obs_sum; got.cout = obs_cout; got.ovf = obs_ovf;
    endtask

    task automatic release_out();
        out_ready_v[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[sel] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid_v = '0; out_ready_v = '0;
        a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
        sel = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({obs_in_ready, obs_out_valid, obs_busy, obs_cout, obs_ovf} !== 5'b10000 || obs_sum !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy/vld/busy/cout/ovf=%b sum=%h, want 10000 sum=0",
                     {obs_in_ready, obs_out_valid, obs_busy, obs_cout, obs_ovf}, obs_sum);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed(input string name, input logic [127:0] av, input logic [127:0] bv,
                                 input logic ci, input logic sub, input exp_t spec);
        int   lat;
        exp_t got, e;
        sb_q.push_back(spec);
        run_op(av, bv, ci, sub, lat, got);
        e = sb_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     name, got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
        end
        n_tests++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, want 4", name, lat);
        end
        release_out();
    endtask

    task automatic test_stall();
        int           lat;
        exp_t         got, e;
        logic [127:0] held;
        sb_q.push_back('{sum: {1'b1, 127'b0}, cout: 1'b0, ovf: 1'b1});
        run_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, lat, got);
        e = sb_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL signed_ovf: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                     got.sum, got.cout, got.ovf, e.sum, e.cout, e.ovf);
        end
        held = obs_sum;
        for (int i = 0; i < 10; i++) begin
            in_valid_v[0] = i[0];
            a_in = {4{$urandom}}; b_in = {4{$urandom}};
            @(posedge clk); #1;
            n_tests++;
            if (obs_sum !== held || obs_in_ready !== 1'b0 || obs_out_valid !== 1'b1 || obs_ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got sum=%h rdy=%b vld=%b ovf=%b, want sum=%h rdy=0 vld=1 ovf=1",
                         i, obs_sum, obs_in_ready, obs_out_valid, obs_ovf, held);
            end
        end
        in_valid_v[0] = 1'b0;
        release_out();
        @(posedge clk); #1;
        n_tests++;
        if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_busy !== 1'b0 || obs_sum !== held) begin
            n_fail++;
            $display("FAIL stall_release: got rdy=%b vld=%b busy=%b sum=%h, want rdy=1 vld=0 busy=0 sum=%h",
                     obs_in_ready, obs_out_valid, obs_busy, obs_sum, held);
        end
    endtask

    task automatic test_reset_mid_add();
        int   lat;
        exp_t got, e;
        a_in = 128'h1234; b_in = 128'h5678; cin_in = 1'b0; sub_in = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({obs_in_ready, obs_out_valid, obs_busy, obs_cout, obs_ovf} !== 5'b10000 || obs_sum !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_add: got rdy/vld/busy/cout/ovf=%b sum=%h, want 10000 sum=0",
                     {obs_in_ready, obs_out_valid, obs_busy, obs_cout, obs_ovf}, obs_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb_q.push_back('{sum: 128'd123, cout: 1'b0, ovf: 1'b0});
        run_op(128'd100, 128'd23, 1'b0, 1'b0, lat, got);
        e = sb_q.pop_front();
        n_tests++;
        if (got !== e || lat !== 4) begin
            n_fail++;
            $display("FAIL after_reset_op: got sum=%h cout=%b ovf=%b lat=%0d, want sum=%h cout=%b ovf=%b lat=4",
                     got.sum, got.cout, got.ovf, lat, e.sum, e.cout, e.ovf);
        end
        release_out();
    endtask

    task automatic test_random(input int s, input int nbits, input int count);
        int           issued, done, cycles;
        logic [127:0] av, bv;
        logic         ci, sb;
        exp_t         e;
        sel = s;
        issued = 0; done = 0; cycles = 0;
        sb_q.delete();
        @(posedge clk); #1;
        while (done < count && cycles < count * 30) begin
            out_ready_v[sel] = ($urandom_range(0, 3) != 0);
            if (obs_out_valid && out_ready_v[sel]) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_w%0d: unexpected result sum=%h with empty scoreboard", nbits, obs_sum);
                end else begin
                    e = sb_q.pop_front();
                    if (obs_sum !== e.sum || obs_cout !== e.cout || obs_ovf !== e.ovf) begin
                        n_fail++;
                        $display("FAIL random_w%0d #%0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                                 nbits, done, obs_sum, obs_cout, obs_ovf, e.sum, e.cout, e.ovf);
                    end
                end
                done++;
            end
            if (obs_in_ready && issued < count && $urandom_range(0, 1) == 1) begin
                av = ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom, $urandom, $urandom};
                bv = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
                ci = $urandom_range(0, 1) == 1;
                sb = $urandom_range(0, 1) == 1;
                a_in = av; b_in = bv; cin_in = ci; sub_in = sb;
                in_valid_v[sel] = 1'b1;
                sb_q.push_back(model(nbits, av, bv, ci, sb));
                issued++;
            end else begin
                in_valid_v[sel] = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid_v[sel] = 1'b0;
        out_ready_v[sel] = 1'b0;
        n_tests++;
        if (done != count || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL random_w%0d_complete: got %0d results (%0d pending), want %0d",
                     nbits, done, sb_q.size(), count);
        end
    endtask

    initial begin
        test_reset();
        test_directed("wrap_all_ones", '1, 128'd1, 1'b0, 1'b0,
                      '{sum: 128'd0, cout: 1'b1, ovf: 1'b0});
        test_directed("sub_5_minus_7", 128'd5, 128'd7, 1'b0, 1'b1,
                      '{sum: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, cout: 1'b0, ovf: 1'b0});
        test_reset_mid_add();
        test_stall();
        test_directed("carry_chain", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd0, 1'b1, 1'b0,
                      '{sum: 128'h1_0000_0000_0000_0000, cout: 1'b0, ovf: 1'b0});
        test_random(0, 128, 1000);
        test_random(1, 32, 1000);
        test_random(2, 24, 1000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
